// File: rtl/score_keeper.sv
// Score keeper: turns per-lane hit/note-end pulses into BCD score, combo,
// multiplier and miss count, servicing at most one buffered event per clock.
module score_keeper #(
  parameter int N_LANES      = 4,
  parameter int SCORE_DIGITS = 4,
  parameter int MAX_MULT     = 4,
  parameter int COMBO_STEP   = 8
) (
  input  logic                      CLOCK_25,
  input  logic                      reset,
  input  logic [N_LANES-1:0]        hit,
  input  logic [N_LANES-1:0]        note_end,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                combo,
  output logic [2:0]                multiplier,
  output logic [7:0]                miss_count,
  output logic                      score_event
);

  logic [N_LANES-1:0] note_end_d;
  logic [N_LANES-1:0] hit_seen;
  logic [N_LANES-1:0] hit_pend;
  logic [N_LANES-1:0] miss_pend;

  logic [N_LANES-1:0] rise;
  logic [N_LANES-1:0] cap_hit;
  logic [N_LANES-1:0] cap_miss;
  logic [N_LANES-1:0] seen_nxt;

  logic [N_LANES-1:0] sel_hit;
  logic [N_LANES-1:0] sel_miss;
  logic               do_hit;
  logic               do_miss;

  logic [4*SCORE_DIGITS-1:0] score_sum;
  logic [7:0]                combo_inc;
  logic [7:0]                miss_inc;
  logic [2:0]                mult_hit;

  // A hit coinciding with the note-end edge still counts; hit_seen then re-arms for the next note
  always_comb begin
    rise     = note_end & ~note_end_d;
    cap_hit  = hit & ~hit_seen;
    cap_miss = rise & ~hit_seen & ~hit;
    seen_nxt = (hit_seen | hit) & ~rise;
  end

  always_comb begin
    sel_hit  = '0;
    sel_miss = '0;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!do_hit && hit_pend[i]) begin
        sel_hit[i] = 1'b1;
        do_hit     = 1'b1;
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (!do_hit && !do_miss && miss_pend[i]) begin
        sel_miss[i] = 1'b1;
        do_miss     = 1'b1;
      end
    end
  end

  // Ripple BCD add of the multiplier; a carry out of the top digit pins the score at all 9s
  always_comb begin
    logic [3:0] carry;
    logic [4:0] dsum;
    score_sum = score_bcd;
    carry     = {1'b0, multiplier};
    dsum      = '0;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      dsum = 5'(score_bcd[4*d +: 4]) + 5'(carry);
      if (dsum > 5'd9) begin
        score_sum[4*d +: 4] = 4'(dsum - 5'd10);
        carry               = 4'd1;
      end else begin
        score_sum[4*d +: 4] = dsum[3:0];
        carry               = 4'd0;
      end
    end
    if (carry != 4'd0)
      score_sum = {SCORE_DIGITS{4'h9}};
  end

  always_comb begin
    int step;
    combo_inc = (combo == 8'd255) ? combo : combo + 8'd1;
    miss_inc  = (miss_count == 8'd255) ? miss_count : miss_count + 8'd1;
    step      = 1 + int'(combo_inc) / COMBO_STEP;
    mult_hit  = (step > MAX_MULT) ? 3'(MAX_MULT) : 3'(step);
  end

  // Capture wins over service on the same flag, so a fresh event is never dropped by a clear
  always_ff @(posedge CLOCK_25) begin
    note_end_d <= note_end;
    if (reset) begin
      hit_seen    <= '0;
      hit_pend    <= '0;
      miss_pend   <= '0;
      score_bcd   <= '0;
      combo       <= 8'd0;
      multiplier  <= 3'd1;
      miss_count  <= 8'd0;
      score_event <= 1'b0;
    end else begin
      hit_seen    <= seen_nxt;
      hit_pend    <= (hit_pend & ~sel_hit) | cap_hit;
      miss_pend   <= (miss_pend & ~sel_miss) | cap_miss;
      score_event <= do_hit;
      if (do_hit) begin
        score_bcd  <= score_sum;
        combo      <= combo_inc;
        multiplier <= mult_hit;
      end else if (do_miss) begin
        miss_count <= miss_inc;
        combo      <= 8'd0;
        multiplier <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a 4-digit instance for the main scenarios
// and a 1-digit instance for saturation and reset-with-pending behaviour.
module tb_score_keeper;

  logic        CLOCK_25;
  logic        reset;
  logic [3:0]  hit, note_end;
  logic [15:0] score_bcd;
  logic [7:0]  combo, miss_count;
  logic [2:0]  multiplier;
  logic        score_event;

  logic [3:0]  hit1, note_end1;
  logic [3:0]  score1;
  logic [7:0]  combo1, miss1;
  logic [2:0]  mult1;
  logic        event1;

  int vectors;
  int miscompares;

  score_keeper #(.N_LANES(4), .SCORE_DIGITS(4), .MAX_MULT(4), .COMBO_STEP(8)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .hit(hit), .note_end(note_end),
    .score_bcd(score_bcd), .combo(combo), .multiplier(multiplier),
    .miss_count(miss_count), .score_event(score_event));

  score_keeper #(.N_LANES(4), .SCORE_DIGITS(1), .MAX_MULT(4), .COMBO_STEP(8)) dut1 (
    .CLOCK_25(CLOCK_25), .reset(reset), .hit(hit1), .note_end(note_end1),
    .score_bcd(score1), .combo(combo1), .multiplier(mult1),
    .miss_count(miss1), .score_event(event1));

  initial CLOCK_25 = 1'b0;
  always #20 CLOCK_25 = ~CLOCK_25;

  // Inputs change and outputs are sampled 1 ns after each rising edge
  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hit = '0; note_end = '0; hit1 = '0; note_end1 = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (score_bcd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_score: got %h expected 0000", score_bcd); end
    vectors++;
    if (combo !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_combo: got %0d expected 0", combo); end
    vectors++;
    if (multiplier !== 3'd1) begin miscompares++; $display("[TB] FAIL reset_mult: got %0d expected 1", multiplier); end
    vectors++;
    if (miss_count !== 8'd0 || score_event !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_miss_event: got %0d/%b expected 0/0", miss_count, score_event);
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    hit = 4'b0001;
    tick();
    hit = '0;
    vectors++;
    if (score_event !== 1'b0 || score_bcd !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL hit_early: got event %b score %h expected 0 0000", score_event, score_bcd);
    end
    tick();
    vectors++;
    if (score_bcd !== 16'h0001 || combo !== 8'd1 || multiplier !== 3'd1 || score_event !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hit_apply: got score %h combo %0d mult %0d event %b expected 0001 1 1 1",
               score_bcd, combo, multiplier, score_event);
    end
    tick();
    vectors++;
    if (score_event !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_pulse_width: got %b expected 0", score_event); end
  endtask

  task automatic test_combo_multiplier();
    do_reset();
    for (int n = 0; n < 9; n++) begin
      hit[1] = 1'b1; tick();
      hit[1] = 1'b0; tick();
      note_end[1] = 1'b1; tick();
      note_end[1] = 1'b0; tick();
      if (n == 7) begin
        vectors++;
        if (score_bcd !== 16'h0008 || multiplier !== 3'd2) begin
          miscompares++; $display("[TB] FAIL combo8: got score %h mult %0d expected 0008 2", score_bcd, multiplier);
        end
      end
    end
    vectors++;
    if (score_bcd !== 16'h0010 || combo !== 8'd9 || multiplier !== 3'd2 || miss_count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL combo9: got score %h combo %0d mult %0d miss %0d expected 0010 9 2 0",
               score_bcd, combo, multiplier, miss_count);
    end
  endtask

  task automatic test_miss();
    note_end[2] = 1'b1;
    tick();
    tick();
    vectors++;
    if (miss_count !== 8'd1 || combo !== 8'd0 || multiplier !== 3'd1 || score_bcd !== 16'h0010) begin
      miscompares++;
      $display("[TB] FAIL miss: got miss %0d combo %0d mult %0d score %h expected 1 0 1 0010",
               miss_count, combo, multiplier, score_bcd);
    end
    tick();
    note_end[2] = 1'b0;
    tick();
    vectors++;
    if (miss_count !== 8'd1) begin miscompares++; $display("[TB] FAIL miss_hold: got %0d expected 1", miss_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hit = 4'b1001;
    tick();
    hit = '0;
    tick();
    vectors++;
    if (score_bcd !== 16'h0001 || score_event !== 1'b1) begin
      miscompares++; $display("[TB] FAIL b2b_first: got score %h event %b expected 0001 1", score_bcd, score_event);
    end
    tick();
    vectors++;
    if (score_bcd !== 16'h0002 || score_event !== 1'b1 || combo !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got score %h event %b combo %0d expected 0002 1 2", score_bcd, score_event, combo);
    end
    tick();
    vectors++;
    if (score_event !== 1'b0 || score_bcd !== 16'h0002) begin
      miscompares++; $display("[TB] FAIL b2b_idle: got event %b score %h expected 0 0002", score_event, score_bcd);
    end
  endtask

  task automatic test_repeat_hits();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      hit[0] = 1'b1; tick();
      hit[0] = 1'b0; tick();
    end
    note_end[0] = 1'b1; tick(); tick();
    note_end[0] = 1'b0; tick();
    vectors++;
    if (score_bcd !== 16'h0001 || combo !== 8'd1 || miss_count !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL repeat_hits: got score %h combo %0d miss %0d expected 0001 1 0", score_bcd, combo, miss_count);
    end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    for (int n = 0; n < 12; n++) begin
      hit1[0] = 1'b1; tick();
      hit1[0] = 1'b0; note_end1[0] = 1'b1; tick();
      note_end1[0] = 1'b0; tick();
      if (n == 7) begin
        vectors++;
        if (score1 !== 4'h8 || mult1 !== 3'd2) begin
          miscompares++; $display("[TB] FAIL sat_pre: got score %h mult %0d expected 8 2", score1, mult1);
        end
      end
    end
    vectors++;
    if (score1 !== 4'h9 || combo1 !== 8'd12 || mult1 !== 3'd2 || miss1 !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL sat: got score %h combo %0d mult %0d miss %0d expected 9 12 2 0", score1, combo1, mult1, miss1);
    end
    hit1 = 4'b0011;
    tick();
    hit1 = '0; reset = 1'b1; note_end1 = 4'b1111;
    tick(); tick();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      vectors++;
      if (event1 !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_event: got %b expected 0", event1); end
    end
    vectors++;
    if (score1 !== 4'h0 || combo1 !== 8'd0 || mult1 !== 3'd1 || miss1 !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset: got score %h combo %0d mult %0d miss %0d expected 0 0 1 0", score1, combo1, mult1, miss1);
    end
    note_end1 = '0;
    tick(); tick();
    vectors++;
    if (miss1 !== 8'd0) begin miscompares++; $display("[TB] FAIL post_reset_miss: got %0d expected 0", miss1); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; hit = '0; note_end = '0; hit1 = '0; note_end1 = '0;
    test_reset();
    test_single_hit();
    test_combo_multiplier();
    test_miss();
    test_back_to_back();
    test_repeat_hits();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
